instr_fetch: RTL and testbench

Instruction-fetch responder that sits between the program counter and the instruction memory bus. It accepts the current PC address and runs a bus read for that address. It returns the 32-bit instruction and raises `iready` for one cycle, which lets the PC advance. An optional single-entry fetch buffer answers repeated fetches of the same address without a bus access.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_buffer.sv | 44 ++++
 rtl/instr_fetch.sv | 109 ++++++++++
 tb/tb_instr_fetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: control-unit op classes, instruction-fetch FSM states
// and the default instruction returned on a fetch fault.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_ALU,
    OP_LOAD,
    OP_STORE,
    OP_BRANCH,
    OP_JUMP,
    OP_SYSTEM
  } cuOPType;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    FAULT
  } fetchStateType;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry fetch buffer (tag, valid, data) used by instr_fetch.
// Only built when INSTR_FETCH_BUFFER_EN is defined.
`ifdef INSTR_FETCH_BUFFER_EN
module fetch_buffer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [31:0]       data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_tag,
  input  logic [31:0]       wr_data,
  input  logic              inval
);

  logic              valid;
  logic [ADDR_W-1:0] tag;
  logic [31:0]       data_q;

  // NOTE: a single entry is cheap, so tag and data are reset along with valid
  // for deterministic outputs; only valid actually gates a hit.
  always_ff @(posedge clk) begin
    if (RST) begin
      valid  <= 1'b0;
      tag    <= '0;
      data_q <= '0;
    end else begin
      if (wr_en) begin
        valid  <= 1'b1;
        tag    <= wr_tag;
        data_q <= wr_data;
      end
      // Invalidate wins over a same-cycle write.
      if (inval) valid <= 1'b0;
    end
  end

  assign hit  = valid && (tag == lookup_addr);
  assign data = data_q;

endmodule
`endif

// File: rtl/instr_fetch.sv
// Instruction-fetch responder between the PC and the instruction memory bus.
// Define INSTR_FETCH_BUFFER_EN to add a single-entry buffer for repeated fetches.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PCaddr,
  input  logic              dbusy,
  input  logic              flush,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       instr,
  output logic              iready,
  output logic              ifault
);

  fetchStateType     state, state_next;
  logic [ADDR_W-1:0] fetch_addr;
  logic              drop;
  logic              sample;
  logic              take_ack;
  logic              buf_hit;
  logic [31:0]       buf_data;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    sample     = 1'b0;
    take_ack   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!dbusy && !flush) begin
          sample = 1'b1;
          if (PCaddr[1:0] != 2'b00) state_next = FAULT;
          else if (buf_hit)         state_next = RESP;
          else                      state_next = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          // A flush seen at any point of the read discards its data.
          take_ack   = !(drop || flush);
          state_next = take_ack ? RESP : IDLE;
        end
      end
      RESP, FAULT: state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= IDLE;
      mem_read   <= 1'b0;
      fetch_addr <= '0;
      instr      <= '0;
      drop       <= 1'b0;
    end else begin
      state <= state_next;
      if (sample) begin
        fetch_addr <= PCaddr;
        if (state_next == FAULT)     instr    <= NOP_INSTR;
        else if (state_next == RESP) instr    <= buf_data;
        else                         mem_read <= 1'b1;
      end
      if (state == REQ) begin
        if (flush) drop <= 1'b1;
        if (mem_ack) begin
          mem_read <= 1'b0;
          drop     <= 1'b0;
          if (take_ack) instr <= mem_rdata;
        end
      end
    end
  end

  // fetch_addr is only written on a sample, so it is stable for the whole read.
  assign mem_addr = fetch_addr;
  assign iready   = ((state == RESP) || (state == FAULT)) && !flush;
  assign ifault   = (state == FAULT) && !flush;

`ifdef INSTR_FETCH_BUFFER_EN
  fetch_buffer #(
    .ADDR_W(ADDR_W)
  ) u_fetch_buffer (
    .clk        (clk),
    .RST        (RST),
    .lookup_addr(PCaddr),
    .hit        (buf_hit),
    .data       (buf_data),
    .wr_en      (take_ack),
    .wr_tag     (fetch_addr),
    .wr_data    (mem_rdata),
    .inval      (flush)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// fetch sequences against a transaction-level model of the fetch rules.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef INSTR_FETCH_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RST;
  logic [31:0] PCaddr;
  logic        dbusy;
  logic        flush;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [31:0] instr;
  logic        iready;
  logic        ifault;

  instr_fetch #(
    .ADDR_W   (32),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk      (clk),
    .RST      (RST),
    .PCaddr   (PCaddr),
    .dbusy    (dbusy),
    .flush    (flush),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .mem_read (mem_read),
    .mem_addr (mem_addr),
    .instr    (instr),
    .iready   (iready),
    .ifault   (ifault)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the single-entry buffer contents.
  bit          m_valid = 1'b0;
  logic [31:0] m_tag   = '0;
  logic [31:0] m_data  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h00A0_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic fetch(input logic [31:0] addr, input int k, input int hold,
                       input bit hold_flush, input int flush_at, input bit flush_resp);
    bit          fault;
    bit          hit;
    bit          dropped;
    logic [31:0] exp_instr;
    PCaddr  = addr;
    dropped = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (hold_flush) flush = 1'b1;
      else            dbusy = 1'b1;
      @(negedge clk);
      check("hold_no_read", mem_read, 1'b0);
      check("hold_no_ready", iready, 1'b0);
      if (hold_flush) m_valid = 1'b0;
    end
    dbusy = 1'b0;
    flush = 1'b0;
    fault = (addr[1:0] != 2'b00);
    hit   = !fault && BUF_EN && m_valid && (m_tag == addr);
    @(negedge clk);
    if (fault || hit) begin
      exp_instr = fault ? NOP : m_data;
      if (flush_resp) begin
        flush = 1'b1;
        #1;
        check("flushed_resp_ready", iready, 1'b0);
        check("flushed_resp_fault", ifault, 1'b0);
        m_valid = 1'b0;
      end else begin
        check("short_ready", iready, 1'b1);
        check("short_fault", ifault, fault);
        check("short_instr", instr, exp_instr);
        check("short_no_read", mem_read, 1'b0);
      end
      @(negedge clk);
      flush = 1'b0;
    end else begin
      for (int j = 0; j <= k; j++) begin
        check("req_read", mem_read, 1'b1);
        check("req_addr", mem_addr, addr);
        check("req_no_ready", iready, 1'b0);
        if (j == flush_at) begin
          flush   = 1'b1;
          m_valid = 1'b0;
          dropped = 1'b1;
        end else begin
          flush = 1'b0;
        end
        if (j == k) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(addr);
        end
        @(negedge clk);
      end
      flush     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (dropped) begin
        check("drop_no_ready", iready, 1'b0);
        check("drop_read_off", mem_read, 1'b0);
      end else begin
        m_valid = 1'b1;
        m_tag   = addr;
        m_data  = mem_word(addr);
        if (flush_resp) begin
          flush = 1'b1;
          #1;
          check("flushed_miss_ready", iready, 1'b0);
          m_valid = 1'b0;
        end else begin
          check("miss_ready", iready, 1'b1);
          check("miss_fault", ifault, 1'b0);
          check("miss_instr", instr, m_data);
          check("miss_read_off", mem_read, 1'b0);
        end
        @(negedge clk);
        flush = 1'b0;
      end
    end
    check("idle_gap_ready", iready, 1'b0);
  endtask

  task automatic reset_in_req(input logic [31:0] addr, input int j);
    PCaddr = addr;
    @(negedge clk);
    for (int i = 0; i < j; i++) @(negedge clk);
    check("pre_reset_read", mem_read, 1'b1);
    RST = 1'b1;
    @(negedge clk);
    check("rst_read_off", mem_read, 1'b0);
    check("rst_no_ready", iready, 1'b0);
    check("rst_instr", instr, 32'h0);
    RST     = 1'b0;
    dbusy   = 1'b1;
    mem_ack = 1'b1;
    m_valid = 1'b0;
    @(negedge clk);
    check("late_ack_ready", iready, 1'b0);
    check("late_ack_read", mem_read, 1'b0);
    mem_ack = 1'b0;
    dbusy   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    logic [31:0] a;
    int          r;
    int          k;
    logic [31:0] bases [6];
    bases = '{32'h10, 32'h14, 32'h20, 32'h24, 32'h100, 32'h1000};

    RST       = 1'b1;
    PCaddr    = '0;
    dbusy     = 1'b1;
    flush     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("reset_read", mem_read, 1'b0);
    check("reset_addr", mem_addr, 32'h0);
    check("reset_instr", instr, 32'h0);
    check("reset_ready", iready, 1'b0);
    check("reset_fault", ifault, 1'b0);
    RST = 1'b0;
    @(negedge clk);
    check("post_reset_idle", mem_read, 1'b0);

    fetch(32'h10, 3, 0, 1'b0, -1, 1'b0);
    fetch(32'h10, 1, 0, 1'b0, -1, 1'b0);
    fetch(32'h06, 2, 0, 1'b0, -1, 1'b0);
    fetch(32'h20, 1, 4, 1'b0, -1, 1'b0);
    fetch(32'h20, 0, 0, 1'b0, -1, 1'b0);
    fetch(32'h24, 2, 0, 1'b0, 1, 1'b0);
    fetch(32'h24, 0, 0, 1'b0, -1, 1'b0);
    fetch(32'h24, 1, 0, 1'b0, -1, 1'b1);
    fetch(32'h24, 1, 0, 1'b0, -1, 1'b0);
    fetch(32'h24, 1, 0, 1'b0, -1, 1'b1);
    fetch(32'h24, 2, 0, 1'b0, 2, 1'b0);
    reset_in_req(32'h14, 1);
    fetch(32'h14, 0, 2, 1'b1, -1, 1'b0);
    fetch(32'h14, 0, 2, 1'b1, -1, 1'b0);

    prev = 32'h14;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        a = prev;
      end else if (r == 9) begin
        a = $urandom;
        if (a[1:0] == 2'b00) a[0] = 1'b1;
      end else begin
        a = bases[$urandom_range(0, 5)];
      end
      k = $urandom_range(0, 4);
      fetch(a, k, ($urandom_range(0, 3) == 3) ? int'($urandom_range(1, 3)) : 0,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, k)) : -1,
            ($urandom_range(0, 9) == 0));
      prev = a;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
